pb_step_counter: RTL and testbench
==================================

# pb_step_counter

Consumes the single-cycle `released` pulse from the push-button release detector and turns it into a bounded up/down step count. Each accepted pulse moves the count by one in the direction given by `dwn`. A holdoff window after each step rejects further pulses and flags them as dropped. The count feeds the display and LED stages downstream.

## Interface

Parameters:
- `WIDTH`, 8: count width in bits.
- `MAX_VAL`, 255: upper count bound, inclusive. Must satisfy `MAX_VAL <= 2**WIDTH-1`. Lower bound is fixed at 0.
- `HOLDOFF`, 4: cycles in which pulses are rejected after an accepted step. 0 disables holdoff.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `released` input 1: single-cycle release pulse from the upstream detector.
- `dwn` input 1: direction, 1 = decrement, 0 = increment; sampled in the same cycle as `released`.
- `clr` input 1: synchronous clear of count and holdoff.
- `cnt` output WIDTH: current count.
- `step` output 1: one-cycle pulse when `cnt` changed on the previous edge.
- `at_max` output 1: `cnt == MAX_VAL`, combinational from `cnt`.
- `at_min` output 1: `cnt == 0`, combinational from `cnt`.
- `busy` output 1: high while in HOLD.
- `drop` output 1: one-cycle pulse for a `released` rejected during HOLD.

## Operation

- FSM states: IDLE, HOLD.
- IDLE with `released`=1: the pulse is accepted and updates `cnt` by ±1.
  - If `HOLDOFF>0`, go to HOLD and load the timer with `HOLDOFF`.
  - If `HOLDOFF=0`, stay in IDLE.
- HOLD: the timer decrements each cycle. On the cycle the timer is 1, return to IDLE.
  - A `released` pulse in HOLD leaves `cnt` and the timer unchanged and produces `drop`.
- Arithmetic: the count is held at WIDTH bits; the bound compare is against `MAX_VAL`, not `2**WIDTH-1`.
- Up at `MAX_VAL` or down at 0 follows the bound mode (see Configuration).
  - When the count does not change, `step` stays low, but the pulse is still accepted and holdoff still starts.
- `clr`=1 has highest priority:
  - `cnt`←0, state←IDLE, timer←0.
  - A coincident `released` is ignored; `step` and `drop` stay low.
- Reset (`rst_n`=0 at an edge) gives the same result as `clr`, mid-holdoff included. During reset, `released` is ignored.

## Timing

- Reset values: `cnt`=0, `step`=0, `busy`=0, `drop`=0, `at_min`=1, `at_max`=0 (for `MAX_VAL>0`).
- `released` high in cycle k and accepted:
  - the new `cnt` and `step`=1 appear in cycle k+1;
  - `step` is low again in cycle k+2.
- Holdoff window:
  - `busy` is high in cycles k+1 through k+HOLDOFF.
  - The earliest next accepted pulse is in cycle k+HOLDOFF+1.
- `drop` is registered: a rejected pulse in cycle j gives `drop` high in cycle j+1.
- `released` is assumed to be a one-cycle pulse. A multi-cycle high with `HOLDOFF=0` counts once per cycle; this is documented, not protected against.
- `step` and `drop` are never both high in the same cycle.

## Configuration

- `PB_COUNTER_WRAP_EN` defined: the count wraps at the bounds.
  - Up from `MAX_VAL` gives 0; down from 0 gives `MAX_VAL`.
  - `step` pulses on every accepted pulse.
- `PB_COUNTER_WRAP_EN` undefined (default): the count saturates at 0 and `MAX_VAL`.
  - Pulses that would cross a bound leave `cnt` unchanged, and `step` stays low.

## Structure

- Shared package `pb_pkg` holds:
  - the state typedef `pb_state_t` {IDLE, HOLD};
  - the default constants `PB_CNT_WIDTH`=8 and `PB_HOLDOFF_DEF`=4.
- Sub-module `pb_holdoff_timer`:
  - a loadable down-counter of width `$clog2(HOLDOFF+1)`;
  - signals: `load`, `clr`, `expire` (high when the count is 1), `active`.
- The FSM, count register and bound logic live in the top module.

## Test plan

- Reset and release: apply reset, then `released` with `dwn`=0.
  - Required: `cnt`=0 and `at_min`=1 during reset.
  - Required: `cnt`=1 and `step`=1 one cycle after the pulse.
- Holdoff rejection (`HOLDOFF`=4): pulses at cycles 10 and 12.
  - Required: `cnt` steps once, `drop` high at cycle 13, `busy` high for cycles 11–14.
  - A pulse at cycle 15 is accepted.
- Down at bound: `cnt`=0, `dwn`=1, pulse.
  - Saturate build: `cnt` stays 0, `step`=0.
  - Wrap build: `cnt`=255, `step`=1.
- Up at a non-power-of-two bound (`MAX_VAL`=9): from `cnt`=9, `dwn`=0, pulse.
  - Saturate build: 9. Wrap build: 0. `at_max` tracks correctly.
- `clr` mid-holdoff together with `released`:
  - Required: next cycle `cnt`=0, `busy`=0, `step`=0, `drop`=0.
  - A pulse the following cycle is accepted.
- Reset in HOLD: assert `rst_n`=0 for one cycle while `busy`=1.
  - Required: all outputs return to reset values, and the next `released` is accepted immediately.

Source files
------------

// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared types and defaults for the push-button step counter
package pb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } pb_state_t;

    localparam int PB_CNT_WIDTH   = 8;
    localparam int PB_HOLDOFF_DEF = 4;

    // Timer width is $clog2(HOLDOFF+1); clamped to one bit so HOLDOFF=0 still elaborates.
    function automatic int pb_timer_width(input int holdoff);
        return (holdoff < 1) ? 1 : $clog2(holdoff + 1);
    endfunction

endpackage

// File: rtl/pb_holdoff_timer.sv
// rtl/pb_holdoff_timer.sv - loadable holdoff down-counter, expire marks the last held cycle
module pb_holdoff_timer
    import pb_pkg::*;
#(
    parameter int HOLDOFF = PB_HOLDOFF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clr,
    output logic expire,
    output logic active
);

    localparam int              TW       = pb_timer_width(HOLDOFF);
    localparam logic [TW-1:0]   LOAD_VAL = TW'(HOLDOFF);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Clear beats load; otherwise count down to zero and rest there.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Timer register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == TW'(1));
    assign active = (count_q != '0);

endmodule

// File: rtl/pb_step_counter.sv
// rtl/pb_step_counter.sv - bounded up/down step counter with holdoff; PB_COUNTER_WRAP_EN selects wrap instead of saturate
module pb_step_counter
    import pb_pkg::*;
#(
    parameter int WIDTH   = PB_CNT_WIDTH,
    parameter int MAX_VAL = 255,
    parameter int HOLDOFF = PB_HOLDOFF_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             released,
    input  logic             dwn,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             step,
    output logic             at_max,
    output logic             at_min,
    output logic             busy,
    output logic             drop
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    pb_state_t        state_q;
    pb_state_t        state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             step_q;
    logic             step_d;
    logic             drop_q;
    logic             drop_d;
    logic             accept;
    logic             reject;
    logic             timer_load;
    logic             timer_expire;
    logic             timer_active;

    pb_holdoff_timer #(
        .HOLDOFF (HOLDOFF)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .clr    (clr),
        .expire (timer_expire),
        .active (timer_active)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an accepted pulse opens the holdoff window (if any); the last timer cycle closes it.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (released && (HOLDOFF > 0)) state_d = HOLD;
                HOLD: if (timer_expire || !timer_active) state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: classify the incoming pulse and drive the timer load.
    always_comb begin
        accept     = 1'b0;
        reject     = 1'b0;
        if (!clr) begin
            accept = (state_q == IDLE) && released;
            reject = (state_q == HOLD) && released;
        end
        timer_load = accept && (HOLDOFF > 0);
    end

    // Count update with bound handling; step only reports an actual change.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (accept) begin
            if (dwn) begin
                if (cnt_q == '0) begin
`ifdef PB_COUNTER_WRAP_EN
                    cnt_d = MAX_C;
`else
                    cnt_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end else begin
                if (cnt_q >= MAX_C) begin
`ifdef PB_COUNTER_WRAP_EN
                    cnt_d = '0;
`else
                    cnt_d = MAX_C;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
        step_d = accept && (cnt_d != cnt_q);
        drop_d = reject;
    end

    // Count and pulse registers; reset matches clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
            drop_q <= drop_d;
        end
    end

    assign cnt    = cnt_q;
    assign step   = step_q;
    assign drop   = drop_q;
    assign busy   = (state_q == HOLD);
    assign at_max = (cnt_q == MAX_C);
    assign at_min = (cnt_q == '0);

endmodule

// File: tb/tb_pb_step_counter.sv
// tb/tb_pb_step_counter.sv - self-checking bench: instance A (8b, max 255, holdoff 4), instance B (4b, max 9, holdoff 0)
module tb_pb_step_counter;

`ifdef PB_COUNTER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk;
    logic       rel_a, dwn_a, clr_a, rstn_a;
    logic       rel_b, dwn_b, clr_b, rstn_b;
    logic [7:0] cnt_a;
    logic [3:0] cnt_b;
    logic       step_a, at_max_a, at_min_a, busy_a, drop_a;
    logic       step_b, at_max_b, at_min_b, busy_b, drop_b;

    int n_chk  = 0;
    int n_fail = 0;

    pb_step_counter #(.WIDTH(8), .MAX_VAL(255), .HOLDOFF(4)) dut_a (
        .clk(clk), .rst_n(rstn_a), .released(rel_a), .dwn(dwn_a), .clr(clr_a),
        .cnt(cnt_a), .step(step_a), .at_max(at_max_a), .at_min(at_min_a),
        .busy(busy_a), .drop(drop_a)
    );

    pb_step_counter #(.WIDTH(4), .MAX_VAL(9), .HOLDOFF(0)) dut_b (
        .clk(clk), .rst_n(rstn_b), .released(rel_b), .dwn(dwn_b), .clr(clr_b),
        .cnt(cnt_b), .step(step_b), .at_max(at_max_b), .at_min(at_min_b),
        .busy(busy_b), .drop(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: count value, pulses, and the last cycle the holdoff window covers.
    int unsigned m_max   [2] = '{255, 9};
    int          m_hold  [2] = '{4, 0};
    int unsigned m_cnt   [2];
    bit          m_step  [2];
    bit          m_drop  [2];
    longint      m_busy_until [2];
    bit          m_valid [2] = '{1'b0, 1'b0};
    longint      cyc = 0;

    always @(posedge clk) begin
        bit r [2];
        bit d [2];
        bit c [2];
        bit n [2];
        r = '{rel_a, rel_b};
        d = '{dwn_a, dwn_b};
        c = '{clr_a, clr_b};
        n = '{rstn_a, rstn_b};
        for (int i = 0; i < 2; i++) begin
            if (!n[i] || c[i]) begin
                m_cnt[i] = 0;
                m_step[i] = 0;
                m_drop[i] = 0;
                m_busy_until[i] = -1;
                if (!n[i]) m_valid[i] = 1'b1;
            end else if (r[i] && cyc <= m_busy_until[i]) begin
                m_step[i] = 0;
                m_drop[i] = 1;
            end else if (r[i]) begin
                int unsigned nx;
                if (d[i]) nx = (m_cnt[i] == 0) ? (WRAP ? m_max[i] : 0) : m_cnt[i] - 1;
                else      nx = (m_cnt[i] == m_max[i]) ? (WRAP ? 0 : m_max[i]) : m_cnt[i] + 1;
                m_step[i] = (nx != m_cnt[i]);
                m_drop[i] = 0;
                m_cnt[i]  = nx;
                m_busy_until[i] = cyc + m_hold[i];
            end else begin
                m_step[i] = 0;
                m_drop[i] = 0;
            end
        end
        cyc++;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid[0]) begin
            chk("a.cnt",    cnt_a,    m_cnt[0]);
            chk("a.step",   step_a,   m_step[0]);
            chk("a.drop",   drop_a,   m_drop[0]);
            chk("a.busy",   busy_a,   (cyc <= m_busy_until[0]) ? 1 : 0);
            chk("a.at_max", at_max_a, (m_cnt[0] == m_max[0]) ? 1 : 0);
            chk("a.at_min", at_min_a, (m_cnt[0] == 0) ? 1 : 0);
        end
        if (m_valid[1]) begin
            chk("b.cnt",    cnt_b,    m_cnt[1]);
            chk("b.step",   step_b,   m_step[1]);
            chk("b.drop",   drop_b,   m_drop[1]);
            chk("b.busy",   busy_b,   (cyc <= m_busy_until[1]) ? 1 : 0);
            chk("b.at_max", at_max_b, (m_cnt[1] == m_max[1]) ? 1 : 0);
            chk("b.at_min", at_min_b, (m_cnt[1] == 0) ? 1 : 0);
        end
    end

    task automatic ta(input logic r, input logic d, input logic c, input logic n);
        rel_a = r; dwn_a = d; clr_a = c; rstn_a = n;
        rel_b = 0; dwn_b = 0; clr_b = 0; rstn_b = 1;
        @(negedge clk);
    endtask

    task automatic tb2(input logic r, input logic d, input logic c, input logic n);
        rel_b = r; dwn_b = d; clr_b = c; rstn_b = n;
        rel_a = 0; dwn_a = 0; clr_a = 0; rstn_a = 1;
        @(negedge clk);
    endtask

    initial begin
        rel_a = 1; dwn_a = 0; clr_a = 0; rstn_a = 0;
        rel_b = 1; dwn_b = 0; clr_b = 0; rstn_b = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.cnt",    cnt_a,    0);
        chk("rst.at_min", at_min_a, 1);
        chk("rst.at_max", at_max_a, 0);
        chk("rst.step",   step_a,   0);
        chk("rst.busy",   busy_a,   0);
        chk("rst.b_cnt",  cnt_b,    0);

        // Reset and release, then a full holdoff window.
        ta(1, 0, 0, 1);
        chk("rel.cnt",  cnt_a,  1);
        chk("rel.step", step_a, 1);
        chk("rel.busy", busy_a, 1);
        ta(0, 0, 0, 1);
        chk("rel.step_low", step_a, 0);
        ta(0, 0, 0, 1);
        ta(0, 0, 0, 1);
        chk("hold.busy_last", busy_a, 1);
        ta(0, 0, 0, 1);
        chk("hold.busy_end", busy_a, 0);

        // Holdoff rejection: pulses at k and k+2, next accepted at k+5.
        ta(1, 0, 0, 1);
        ta(0, 0, 0, 1);
        ta(1, 0, 0, 1);
        chk("rej.drop", drop_a, 1);
        chk("rej.cnt",  cnt_a,  2);
        chk("rej.step", step_a, 0);
        ta(0, 0, 0, 1);
        chk("rej.drop_low", drop_a, 0);
        chk("rej.busy4",    busy_a, 1);
        ta(0, 0, 0, 1);
        chk("rej.busy_end", busy_a, 0);
        ta(1, 0, 0, 1);
        chk("rej.next_cnt",  cnt_a,  3);
        chk("rej.next_step", step_a, 1);

        // Down at lower bound.
        ta(0, 0, 1, 1);
        chk("clr.cnt", cnt_a, 0);
        ta(1, 1, 0, 1);
        chk("dn0.cnt",  cnt_a,  WRAP ? 255 : 0);
        chk("dn0.step", step_a, WRAP ? 1 : 0);
        chk("dn0.busy", busy_a, 1);
        repeat (4) ta(0, 0, 0, 1);

        // Climb to the upper bound, then one more.
        ta(0, 0, 1, 1);
        for (int i = 0; i < 255; i++) begin
            ta(1, 0, 0, 1);
            repeat (4) ta(0, 0, 0, 1);
        end
        chk("up.cnt",    cnt_a,    255);
        chk("up.at_max", at_max_a, 1);
        ta(1, 0, 0, 1);
        chk("upmax.cnt",  cnt_a,  WRAP ? 0 : 255);
        chk("upmax.step", step_a, WRAP ? 1 : 0);
        repeat (4) ta(0, 0, 0, 1);

        // Clear mid-holdoff together with a release.
        ta(1, 1, 0, 1);
        ta(1, 0, 1, 1);
        chk("clrh.cnt",  cnt_a,  0);
        chk("clrh.busy", busy_a, 0);
        chk("clrh.step", step_a, 0);
        chk("clrh.drop", drop_a, 0);
        ta(1, 0, 0, 1);
        chk("clrh.next_cnt",  cnt_a,  1);
        chk("clrh.next_step", step_a, 1);

        // Reset while in holdoff.
        chk("rsth.pre_busy", busy_a, 1);
        ta(1, 0, 0, 0);
        chk("rsth.cnt",    cnt_a,    0);
        chk("rsth.busy",   busy_a,   0);
        chk("rsth.step",   step_a,   0);
        chk("rsth.drop",   drop_a,   0);
        chk("rsth.at_min", at_min_a, 1);
        ta(1, 0, 0, 1);
        chk("rsth.next_cnt",  cnt_a,  1);
        chk("rsth.next_step", step_a, 1);
        repeat (4) ta(0, 0, 0, 1);

        // Instance B: bound 9, no holdoff, held-high release counts every cycle.
        tb2(0, 0, 1, 1);
        for (int i = 0; i < 9; i++) tb2(1, 0, 0, 1);
        chk("b9.cnt",    cnt_b,    9);
        chk("b9.at_max", at_max_b, 1);
        chk("b9.busy",   busy_b,   0);
        tb2(1, 0, 0, 1);
        chk("b9up.cnt",    cnt_b,    WRAP ? 0 : 9);
        chk("b9up.step",   step_b,   WRAP ? 1 : 0);
        chk("b9up.at_max", at_max_b, WRAP ? 0 : 1);
        tb2(0, 0, 0, 1);
        tb2(1, 1, 0, 1);
        tb2(0, 0, 0, 1);
        tb2(1, 1, 0, 1);
        tb2(0, 0, 1, 1);
        tb2(1, 1, 0, 1);
        chk("b0dn.cnt",  cnt_b,  WRAP ? 9 : 0);
        chk("b0dn.step", step_b, WRAP ? 1 : 0);
        tb2(1, 1, 0, 1);
        tb2(1, 0, 0, 1);
        repeat (2) tb2(0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
